ats21_cmd_sequencer: RTL and testbench

ATS21_CMD_SEQUENCER -- requirements
Module: ats21_cmd_sequencer

---
 rtl/ats21_cmd_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_ats21_cmd_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ats21_cmd_sequencer.sv
// Two-client command sequencer for the ATS21: per-client FIFOs, conflict arbitration,
// and a fixed handshake that ships each 32-bit lane word as two 16-bit halves.

module ats21_cmd_fifo #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        push,
   input  logic [31:0] din,
   input  logic        pop,
   output logic [31:0] dout,
   output logic        empty,
   output logic        full
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] mem_d [DEPTH];
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign dout  = mem_q[rd_q[AW-1:0]];

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push && !full) begin
         mem_d[wr_q[AW-1:0]] = din;
         wr_d = wr_q + (AW+1)'(1);
      end
      if (pop && !empty) begin
         rd_d = rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         mem_q <= mem_d;
      end
   end
endmodule

module ats21_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        a_valid,
   input  logic [31:0] a_inst,
   output logic        a_ready,
   output logic        a_rsp_valid,
   output logic [1:0]  a_rsp_code,
   input  logic        b_valid,
   input  logic [31:0] b_inst,
   output logic        b_ready,
   output logic        b_rsp_valid,
   output logic [1:0]  b_rsp_code,
   output logic        ats_req,
   input  logic        ats_ready,
   output logic [15:0] ats_ctrlA,
   output logic [15:0] ats_ctrlB,
   input  logic [1:0]  ats_stat,
   output logic        busy
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT_RDY, S_HI, S_LO, S_EXEC, S_STAT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   lane_a_q, lane_a_d, lane_b_q, lane_b_d;
   logic          iss_a_q, iss_a_d, iss_b_q, iss_b_d;
   logic          rr_q, rr_d;
   logic          a_rsp_valid_q, a_rsp_valid_d, b_rsp_valid_q, b_rsp_valid_d;
   logic [1:0]    a_rsp_code_q, a_rsp_code_d, b_rsp_code_q, b_rsp_code_d;
   logic          pop_a, pop_b;
   logic [31:0]   a_head, b_head;
   logic          a_empty, a_full, b_empty, b_full;
   logic [2:0]    op_a, op_b;
   logic          conflict;

   ats21_cmd_fifo #(.DEPTH(DEPTH)) u_fifo_a (
      .clk(clk), .reset_n(reset_n), .push(a_valid), .din(a_inst), .pop(pop_a),
      .dout(a_head), .empty(a_empty), .full(a_full)
   );

   ats21_cmd_fifo #(.DEPTH(DEPTH)) u_fifo_b (
      .clk(clk), .reset_n(reset_n), .push(b_valid), .din(b_inst), .pop(pop_b),
      .dout(b_head), .empty(b_empty), .full(b_full)
   );

   assign op_a = a_head[31:29];
   assign op_b = b_head[31:29];

   // Two heads that would drive the same ATS21 resource cannot be issued together.
   assign conflict = !a_empty && !b_empty &&
                     ((op_a == 3'b011 && op_b == 3'b011) ||
                      (op_a == op_b && (op_a == 3'b001 || op_a == 3'b010) &&
                       a_head[28:25] == b_head[28:25]) ||
                      (op_a >= 3'b101 && op_b >= 3'b101 && a_head[28:24] == b_head[28:24]));

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      lane_a_d      = lane_a_q;
      lane_b_d      = lane_b_q;
      iss_a_d       = iss_a_q;
      iss_b_d       = iss_b_q;
      rr_d          = rr_q;
      a_rsp_valid_d = 1'b0;
      b_rsp_valid_d = 1'b0;
      a_rsp_code_d  = a_rsp_code_q;
      b_rsp_code_d  = b_rsp_code_q;
      pop_a         = 1'b0;
      pop_b         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!a_empty || !b_empty) begin
               iss_a_d  = !a_empty && (!conflict || !rr_q);
               iss_b_d  = !b_empty && (!conflict || rr_q);
               lane_a_d = iss_a_d ? a_head : 32'h0;
               lane_b_d = iss_b_d ? b_head : 32'h0;
               if (conflict) begin
                  rr_d = !rr_q;
               end
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            cnt_d   = '0;
            state_d = S_WAIT_RDY;
         end
         S_WAIT_RDY: begin
            if (ats_ready) begin
               state_d = S_HI;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               // Timed out: retire whatever was issued with a timeout code.
               state_d       = S_IDLE;
               a_rsp_valid_d = iss_a_q;
               b_rsp_valid_d = iss_b_q;
               a_rsp_code_d  = iss_a_q ? 2'b10 : a_rsp_code_q;
               b_rsp_code_d  = iss_b_q ? 2'b10 : b_rsp_code_q;
               pop_a         = iss_a_q;
               pop_b         = iss_b_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_HI:   state_d = S_LO;
         S_LO:   state_d = S_EXEC;
         S_EXEC: state_d = S_STAT;
         S_STAT: begin
            state_d       = S_IDLE;
            a_rsp_valid_d = iss_a_q;
            b_rsp_valid_d = iss_b_q;
            a_rsp_code_d  = iss_a_q ? (ats_stat[0] ? 2'b00 : 2'b01) : a_rsp_code_q;
            b_rsp_code_d  = iss_b_q ? (ats_stat[1] ? 2'b00 : 2'b01) : b_rsp_code_q;
            pop_a         = iss_a_q;
            pop_b         = iss_b_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         lane_a_q      <= '0;
         lane_b_q      <= '0;
         iss_a_q       <= 1'b0;
         iss_b_q       <= 1'b0;
         rr_q          <= 1'b0;
         a_rsp_valid_q <= 1'b0;
         b_rsp_valid_q <= 1'b0;
         a_rsp_code_q  <= 2'b00;
         b_rsp_code_q  <= 2'b00;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         lane_a_q      <= lane_a_d;
         lane_b_q      <= lane_b_d;
         iss_a_q       <= iss_a_d;
         iss_b_q       <= iss_b_d;
         rr_q          <= rr_d;
         a_rsp_valid_q <= a_rsp_valid_d;
         b_rsp_valid_q <= b_rsp_valid_d;
         a_rsp_code_q  <= a_rsp_code_d;
         b_rsp_code_q  <= b_rsp_code_d;
      end
   end

   always_comb begin
      ats_ctrlA = 16'h0;
      ats_ctrlB = 16'h0;
      if (state_q == S_HI) begin
         ats_ctrlA = lane_a_q[31:16];
         ats_ctrlB = lane_b_q[31:16];
      end else if (state_q == S_LO) begin
         ats_ctrlA = lane_a_q[15:0];
         ats_ctrlB = lane_b_q[15:0];
      end
   end

   assign ats_req     = (state_q == S_REQ);
   assign busy        = (state_q != S_IDLE);
   assign a_ready     = !a_full;
   assign b_ready     = !b_full;
   assign a_rsp_valid = a_rsp_valid_q;
   assign b_rsp_valid = b_rsp_valid_q;
   assign a_rsp_code  = a_rsp_code_q;
   assign b_rsp_code  = b_rsp_code_q;
endmodule

// File: tb/tb_ats21_cmd_sequencer.sv
// Bench for ats21_cmd_sequencer: directed scenarios then random traffic, all checked
// against a transaction-level model that tracks each command by its age in cycles.

module tb_ats21_cmd_sequencer;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        a_valid, b_valid;
   logic [31:0] a_inst, b_inst;
   logic        a_ready, b_ready;
   logic        a_rsp_valid, b_rsp_valid;
   logic [1:0]  a_rsp_code, b_rsp_code;
   logic        ats_req;
   logic        ats_ready;
   logic [15:0] ats_ctrlA, ats_ctrlB;
   logic [1:0]  ats_stat;
   logic        busy;

   ats21_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_valid(a_valid), .a_inst(a_inst), .a_ready(a_ready),
      .a_rsp_valid(a_rsp_valid), .a_rsp_code(a_rsp_code),
      .b_valid(b_valid), .b_inst(b_inst), .b_ready(b_ready),
      .b_rsp_valid(b_rsp_valid), .b_rsp_code(b_rsp_code),
      .ats_req(ats_req), .ats_ready(ats_ready),
      .ats_ctrlA(ats_ctrlA), .ats_ctrlB(ats_ctrlB),
      .ats_stat(ats_stat), .busy(busy)
   );

   always #5 clk = ~clk;

   int testsRun = 0;
   int failures = 0;
   int obsRspA = 0;
   int obsRspB = 0;

   // Reference model: client queues plus one in-flight transaction described by its
   // issued words, its age since the request cycle and the ready delay chosen for it.
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   bit          mActive;
   int          mAge;
   int          mK;
   bit          mIssA, mIssB;
   logic [31:0] mWordA, mWordB;
   logic [1:0]  mStat;
   bit          mRr;
   bit          expRspA, expRspB;
   logic [1:0]  expCodeA, expCodeB;
   int          forcedK = -1;
   int          forcedStat = -1;

   function automatic bit cmdConflict(input logic [31:0] x, input logic [31:0] y);
      int ox = int'(x[31:29]);
      int oy = int'(y[31:29]);
      if (ox == 3 && oy == 3) return 1'b1;
      if (ox == oy && (ox == 1 || ox == 2) && x[28:25] == y[28:25]) return 1'b1;
      if (ox >= 5 && oy >= 5 && x[28:24] == y[28:24]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] randInst();
      logic [2:0] op  = 3'($urandom_range(0, 7));
      logic [4:0] fld = 5'($urandom_range(0, 3));
      return {op, fld, 24'($urandom)};
   endfunction

   task automatic modelReset();
      qa.delete();
      qb.delete();
      mActive = 1'b0;
      mAge    = 0;
      mRr     = 1'b0;
      expRspA = 1'b0;
      expRspB = 1'b0;
      mStat   = 2'b00;
   endtask

   // Advance the model across one rising edge using the inputs held during that edge.
   task automatic modelEdge();
      bit pushA, pushB, conf, timedOut;
      int endAge;
      expRspA = 1'b0;
      expRspB = 1'b0;
      if (!reset_n) begin
         modelReset();
         return;
      end
      pushA = a_valid && (qa.size() < DEPTH);
      pushB = b_valid && (qb.size() < DEPTH);
      if (mActive) begin
         mAge++;
         timedOut = (mK >= TIMEOUT);
         endAge   = timedOut ? TIMEOUT + 1 : 6 + mK;
         if (mAge == endAge) begin
            mActive = 1'b0;
            if (mIssA) begin
               expRspA  = 1'b1;
               expCodeA = timedOut ? 2'b10 : (mStat[0] ? 2'b00 : 2'b01);
               void'(qa.pop_front());
            end
            if (mIssB) begin
               expRspB  = 1'b1;
               expCodeB = timedOut ? 2'b10 : (mStat[1] ? 2'b00 : 2'b01);
               void'(qb.pop_front());
            end
         end
      end else if (qa.size() > 0 || qb.size() > 0) begin
         conf   = (qa.size() > 0) && (qb.size() > 0) && cmdConflict(qa[0], qb[0]);
         mIssA  = (qa.size() > 0) && (!conf || !mRr);
         mIssB  = (qb.size() > 0) && (!conf || mRr);
         mWordA = mIssA ? qa[0] : 32'h0;
         mWordB = mIssB ? qb[0] : 32'h0;
         if (conf) mRr = !mRr;
         mK      = (forcedK >= 0) ? forcedK : int'($urandom_range(0, TIMEOUT + 1));
         mStat   = (forcedStat >= 0) ? 2'(forcedStat) : 2'($urandom_range(0, 3));
         mActive = 1'b1;
         mAge    = 0;
      end
      if (pushA) qa.push_back(a_inst);
      if (pushB) qb.push_back(b_inst);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll();
      logic [15:0] eA = 16'h0;
      logic [15:0] eB = 16'h0;
      if (mActive && mK < TIMEOUT && mAge == 2 + mK) begin
         eA = mWordA[31:16];
         eB = mWordB[31:16];
      end else if (mActive && mK < TIMEOUT && mAge == 3 + mK) begin
         eA = mWordA[15:0];
         eB = mWordB[15:0];
      end
      checkOutput("a_ready", 32'(a_ready), 32'(qa.size() < DEPTH));
      checkOutput("b_ready", 32'(b_ready), 32'(qb.size() < DEPTH));
      checkOutput("busy", 32'(busy), 32'(mActive));
      checkOutput("ats_req", 32'(ats_req), 32'(mActive && mAge == 0));
      checkOutput("ats_ctrlA", 32'(ats_ctrlA), 32'(eA));
      checkOutput("ats_ctrlB", 32'(ats_ctrlB), 32'(eB));
      checkOutput("a_rsp_valid", 32'(a_rsp_valid), 32'(expRspA));
      checkOutput("b_rsp_valid", 32'(b_rsp_valid), 32'(expRspB));
      if (expRspA) checkOutput("a_rsp_code", 32'(a_rsp_code), 32'(expCodeA));
      if (expRspB) checkOutput("b_rsp_code", 32'(b_rsp_code), 32'(expCodeB));
      if (a_rsp_valid) obsRspA++;
      if (b_rsp_valid) obsRspB++;
   endtask

   task automatic applyStimulus(input bit av, input logic [31:0] ai,
                                input bit bv, input logic [31:0] bi);
      a_valid = av;
      a_inst  = ai;
      b_valid = bv;
      b_inst  = bi;
      @(posedge clk);
      modelEdge();
      #1;
      checkAll();
      a_valid   = 1'b0;
      b_valid   = 1'b0;
      ats_ready = mActive && (mK < TIMEOUT) && (mAge == 1 + mK);
      ats_stat  = mStat;
   endtask

   task automatic waitRsp(input string tag, input int maxCycles, output int cycles);
      bit seen = 1'b0;
      cycles = 0;
      for (int i = 1; i <= maxCycles && !seen; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
         if (a_rsp_valid || b_rsp_valid) begin
            seen   = 1'b1;
            cycles = i;
         end
      end
      checkOutput(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      int cyc, baseA, baseB;
      reset_n   = 1'b0;
      a_valid   = 1'b0;
      b_valid   = 1'b0;
      a_inst    = 32'h0;
      b_inst    = 32'h0;
      ats_ready = 1'b0;
      ats_stat  = 2'b00;
      modelReset();

      // Reset state, held across a couple of edges.
      applyStimulus(1'b1, 32'h2400_0010, 1'b1, 32'h4600_0000);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("reset_a_code", 32'(a_rsp_code), 32'd0);
      checkOutput("reset_b_code", 32'(b_rsp_code), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Single A command, ready one cycle after request, lane A acked.
      forcedK    = 0;
      forcedStat = 1;
      applyStimulus(1'b1, 32'h2400_0010, 1'b0, 32'h0);
      waitRsp("req030_wait", 20, cyc);
      checkOutput("req030_latency", 32'(cyc), 32'd7);
      checkOutput("req030_a_rsp", 32'(a_rsp_valid), 32'd1);
      checkOutput("req030_a_code", 32'(a_rsp_code), 32'd0);
      checkOutput("req030_b_rsp", 32'(b_rsp_valid), 32'd0);

      // Same-clock conflict twice: A wins first, then B wins the next one.
      forcedStat = 3;
      applyStimulus(1'b1, 32'h4600_0000, 1'b1, 32'h4600_0001);
      waitRsp("req031_w1", 20, cyc);
      checkOutput("req031_first_a", 32'({a_rsp_valid, b_rsp_valid}), 32'b10);
      waitRsp("req031_w2", 20, cyc);
      checkOutput("req031_then_b", 32'({a_rsp_valid, b_rsp_valid}), 32'b01);
      applyStimulus(1'b1, 32'h4600_0002, 1'b1, 32'h4600_0003);
      waitRsp("req031_w3", 20, cyc);
      checkOutput("req031_second_b", 32'({a_rsp_valid, b_rsp_valid}), 32'b01);
      waitRsp("req031_w4", 20, cyc);
      checkOutput("req031_second_a", 32'({a_rsp_valid, b_rsp_valid}), 32'b10);

      // Alarm 5 vs timer 5 conflicts; alarm 5 vs alarm 6 issues together.
      applyStimulus(1'b1, 32'hA500_0000, 1'b1, 32'hC500_0000);
      waitRsp("req032_w1", 20, cyc);
      checkOutput("req032_first_a", 32'({a_rsp_valid, b_rsp_valid}), 32'b10);
      waitRsp("req032_w2", 20, cyc);
      checkOutput("req032_then_b", 32'({a_rsp_valid, b_rsp_valid}), 32'b01);
      applyStimulus(1'b1, 32'hA500_0000, 1'b1, 32'hA600_0000);
      waitRsp("req032_w3", 20, cyc);
      checkOutput("req032_together", 32'({a_rsp_valid, b_rsp_valid}), 32'b11);

      // Ready never arrives: both lanes time out together.
      forcedK = TIMEOUT;
      applyStimulus(1'b1, 32'h2000_0000, 1'b1, 32'h8000_0000);
      waitRsp("req033_wait", 30, cyc);
      checkOutput("req033_latency", 32'(cyc), 32'(TIMEOUT + 2));
      checkOutput("req033_both", 32'({a_rsp_valid, b_rsp_valid}), 32'b11);
      checkOutput("req033_codes", 32'({a_rsp_code, b_rsp_code}), 32'b1010);
      checkOutput("req033_idle", 32'(busy), 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("req033_drained", 32'(busy), 32'd0);

      // Five back-to-back A pushes while busy with a B command.
      forcedK = 0;
      baseA   = obsRspA;
      baseB   = obsRspB;
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0001);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'h2000_0010 + 32'(i), 1'b0, 32'h0);
         if (i >= 3) checkOutput("req034_a_ready", 32'(a_ready), 32'd0);
      end
      for (int i = 0; i < 60; i++) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("req034_a_count", 32'(obsRspA - baseA), 32'd4);
      checkOutput("req034_b_count", 32'(obsRspB - baseB), 32'd1);

      // Reset asserted during the HI beat.
      applyStimulus(1'b1, 32'h2400_0010, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("req035_hi", 32'(ats_ctrlA), 32'h2400);
      #2;
      reset_n   = 1'b0;
      ats_ready = 1'b0;
      modelReset();
      #1;
      checkOutput("req035_ctrlA", 32'(ats_ctrlA), 32'd0);
      checkOutput("req035_ctrlB", 32'(ats_ctrlB), 32'd0);
      checkOutput("req035_busy", 32'(busy), 32'd0);
      checkOutput("req035_req", 32'(ats_req), 32'd0);
      checkOutput("req035_ready", 32'({a_ready, b_ready}), 32'b11);
      @(negedge clk);
      reset_n = 1'b1;
      baseA   = obsRspA;
      baseB   = obsRspB;
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("req035_no_rsp", 32'((obsRspA - baseA) + (obsRspB - baseB)), 32'd0);

      // Random traffic with random ready delays (some timing out) and status.
      forcedK    = -1;
      forcedStat = -1;
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 99) < 35, randInst(),
                       $urandom_range(0, 99) < 35, randInst());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end
endmodule
